// File: rtl/fsk_symbol_encoder.sv
// Multi-level FSK encoder: buffers symbols in a FIFO and emits each as a square wave.
// Optional FSK_PREAMBLE_EN adds an out-of-alphabet preamble tone before each burst.
module fsk_symbol_encoder #(
    parameter int SYM_W       = 2,
    parameter int BASE_HALF   = 4,
    parameter int STEP_HALF   = 2,
    parameter int SYM_PERIODS = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               sym_valid,
    input  logic [SYM_W-1:0]                   sym_data,
    output logic                               sym_ready,
    output logic                               pulse_out,
    output logic                               busy,
    output logic [SYM_W-1:0]                   sym_active,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_PH = CNT_W'(2 * SYM_PERIODS - 1);

`ifdef FSK_PREAMBLE_EN
    localparam logic [CNT_W-1:0] PRE_HALF = CNT_W'(BASE_HALF + (2 ** SYM_W) * STEP_HALF);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(3);
    typedef enum logic [1:0] {IDLE, TONE, PRE} state_t;
`else
    typedef enum logic [1:0] {IDLE, TONE} state_t;
`endif

    function automatic logic [CNT_W-1:0] half_of(input logic [SYM_W-1:0] s);
        return CNT_W'(BASE_HALF) + CNT_W'(s) * CNT_W'(STEP_HALF);
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   half_cnt_q, half_cnt_d;
    logic [CNT_W-1:0]   half_val_q, half_val_d;
    logic [CNT_W-1:0]   phase_q, phase_d;
    logic               pulse_q, pulse_d;
    logic [SYM_W-1:0]   sym_q, sym_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [SYM_W-1:0]   mem_q [FIFO_DEPTH];
    logic               push, pop, load;
    logic [SYM_W-1:0]   head;

    assign sym_ready  = (level_q != LW'(FIFO_DEPTH));
    assign push       = sym_valid && sym_ready;
    assign head       = mem_q[rd_ptr_q];
    assign pulse_out  = pulse_q;
    assign busy       = (state_q != IDLE);
    assign sym_active = sym_q;
    assign fifo_level = level_q;

    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        half_val_d = half_val_q;
        phase_d    = phase_q;
        pulse_d    = pulse_q;
        sym_d      = sym_q;
        load       = 1'b0;
        if (enable) begin
            unique case (state_q)
                IDLE: begin
                    if (level_q != '0) begin
`ifdef FSK_PREAMBLE_EN
                        state_d    = PRE;
                        half_val_d = PRE_HALF;
                        half_cnt_d = PRE_HALF;
                        phase_d    = '0;
                        pulse_d    = 1'b1;
`else
                        load = 1'b1;
`endif
                    end
                end
                TONE: begin
                    if (half_cnt_q > CNT_W'(1)) begin
                        half_cnt_d = half_cnt_q - CNT_W'(1);
                    end else if (phase_q != LAST_PH) begin
                        pulse_d    = !pulse_q;
                        half_cnt_d = half_val_q;
                        phase_d    = phase_q + CNT_W'(1);
                    end else if (level_q != '0) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        pulse_d = 1'b0;
                        phase_d = '0;
                    end
                end
`ifdef FSK_PREAMBLE_EN
                PRE: begin
                    if (half_cnt_q > CNT_W'(1)) begin
                        half_cnt_d = half_cnt_q - CNT_W'(1);
                    end else if (phase_q != PRE_LAST) begin
                        pulse_d    = !pulse_q;
                        half_cnt_d = half_val_q;
                        phase_d    = phase_q + CNT_W'(1);
                    end else begin
                        load = 1'b1;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
        // Symbol load always starts with a high phase, keeping the stream phase continuous
        if (load) begin
            state_d    = TONE;
            sym_d      = head;
            half_val_d = half_of(head);
            half_cnt_d = half_of(head);
            phase_d    = '0;
            pulse_d    = 1'b1;
        end
    end

    always_comb begin
        pop      = load;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= sym_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            half_cnt_q <= '0;
            half_val_q <= '0;
            phase_q    <= '0;
            pulse_q    <= 1'b0;
            sym_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            half_val_q <= half_val_d;
            phase_q    <= phase_d;
            pulse_q    <= pulse_d;
            sym_q      <= sym_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

endmodule
